// File: rtl/bert_check.sv
// bert_check: multi-lane bit-error-rate checker for word-aligned serdes loopback data.
// Per lane: pattern compare -> registered mismatch vector -> popcount, lock FSM, saturating counters.
module bert_check #(
    parameter int BW       = 64,
    parameter int LANES    = 2,
    parameter int ECW      = 64,
    parameter int RCW      = 58,
    parameter int LOCK_N   = 16,
    parameter int UNLOCK_N = 4
) (
    input  logic                 CLK,
    input  logic                 RSTX,
    input  logic                 CLR,
    input  logic [1:0]           MODE,
    input  logic                 INV,
    input  logic [LANES*BW-1:0]  DIN,
    input  logic [LANES-1:0]     DIPUSH,
    output logic [LANES-1:0]     LOCKED,
    output logic [LANES*ECW-1:0] ERR_CNT,
    output logic [LANES*RCW-1:0] RECV_CNT,
    output logic                 ERR_ANY
);
    localparam int WW  = $clog2(BW + 1);
    localparam int GW  = $clog2(LOCK_N + 1);
    localparam int BDW = $clog2(UNLOCK_N + 1);
    localparam logic [BW-1:0] ALT_PAT = BW'({((BW + 1) / 2){2'b10}});

    typedef enum logic { ST_HUNT = 1'b0, ST_LOCKED = 1'b1 } state_e;

    logic [1:0]       mode_q;
    logic             modeChg;
    logic [LANES-1:0] laneHit;
    logic             errAny_q, errAny_d;

    assign modeChg  = (MODE != mode_q);
    assign errAny_d = CLR ? 1'b0 : (errAny_q | (|laneHit));
    assign ERR_ANY  = errAny_q;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            mode_q   <= 2'd0;
            errAny_q <= 1'b0;
        end else begin
            mode_q   <= MODE;
            errAny_q <= errAny_d;
        end
    end

    for (genvar ln = 0; ln < LANES; ln++) begin : gLane
        logic [BW-1:0]  d, expw, e1_q;
        logic [6:0]     hist_q;
        logic [BW:0]    s;
        logic           hvalid_q, hvalidEff, judged, v1_q, hit;
        logic [WW-1:0]  w;
        state_e         state_q, state_d;
        logic [GW-1:0]  good_q, good_d;
        logic [BDW-1:0] bad_q, bad_d;
        logic [ECW-1:0] err_q, err_d;
        logic [RCW-1:0] recv_q, recv_d;
        logic [ECW:0]   errSum;

        // PRBS7 taps look back 6 and 7 bits, so only the top 7 bits of the previous word are kept.
        always_comb begin
            d    = INV ? ~DIN[ln*BW +: BW] : DIN[ln*BW +: BW];
            s    = {d[BW-7:0], hist_q};
            expw = '0;
            case (MODE)
                2'd0:    for (int k = 0; k < BW; k++) expw[k] = s[k+1] ^ s[k];
                2'd1:    expw = ALT_PAT;
                2'd2:    expw = '0;
                default: expw = '1;
            endcase
            hvalidEff = hvalid_q & ~modeChg;
            judged    = DIPUSH[ln] & ((MODE != 2'd0) | hvalidEff);
        end

        always_ff @(posedge CLK or negedge RSTX) begin
            if (!RSTX) begin
                hist_q   <= '0;
                hvalid_q <= 1'b0;
                e1_q     <= '0;
                v1_q     <= 1'b0;
            end else begin
                v1_q     <= judged;
                hvalid_q <= DIPUSH[ln] | hvalidEff;
                if (judged) e1_q <= d ^ expw;
                if (DIPUSH[ln]) hist_q <= d[BW-1:BW-7];
            end
        end

        always_comb begin
            w = '0;
            for (int k = 0; k < BW; k++) w = w + WW'(e1_q[k]);
        end

        // Counting uses the pre-update state, so the locking word is skipped and the unlocking word is counted.
        always_comb begin
            state_d = state_q;
            good_d  = good_q;
            bad_d   = bad_q;
            err_d   = err_q;
            recv_d  = recv_q;
            hit     = 1'b0;
            errSum  = {1'b0, err_q} + (ECW + 1)'(w);
            if (v1_q) begin
                if (state_q == ST_HUNT) begin
                    if (w == '0) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_N - 1)) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else begin
                    recv_d = (&recv_q) ? recv_q : recv_q + RCW'(1);
                    err_d  = errSum[ECW] ? '1 : errSum[ECW-1:0];
                    hit    = (w != '0);
                    if (w != '0) begin
                        bad_d = bad_q + BDW'(1);
                        if (bad_q == BDW'(UNLOCK_N - 1)) begin
                            state_d = ST_HUNT;
                            good_d  = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            end
            if (modeChg) begin
                state_d = ST_HUNT;
                good_d  = '0;
                bad_d   = '0;
            end
            if (CLR) begin
                err_d  = '0;
                recv_d = '0;
                hit    = 1'b0;
            end
        end

        always_ff @(posedge CLK or negedge RSTX) begin
            if (!RSTX) begin
                state_q <= ST_HUNT;
                good_q  <= '0;
                bad_q   <= '0;
                err_q   <= '0;
                recv_q  <= '0;
            end else begin
                state_q <= state_d;
                good_q  <= good_d;
                bad_q   <= bad_d;
                err_q   <= err_d;
                recv_q  <= recv_d;
            end
        end

        assign laneHit[ln]              = hit;
        assign LOCKED[ln]               = (state_q == ST_LOCKED);
        assign ERR_CNT[ln*ECW +: ECW]   = err_q;
        assign RECV_CNT[ln*RCW +: RCW]  = recv_q;
    end

endmodule

// File: tb/tb_bert_check.sv
// Self-checking bench for bert_check: directed phases plus randomized traffic against a word-level model.
// A second instance with narrow counters exercises saturation on the same stimulus.
module tb_bert_check;
    localparam int BW       = 64;
    localparam int LANES    = 2;
    localparam int ECW      = 64;
    localparam int RCW      = 58;
    localparam int SECW     = 8;
    localparam int SRCW     = 4;
    localparam int LOCK_N   = 16;
    localparam int UNLOCK_N = 4;
    localparam logic [BW-1:0] ALT  = {(BW/2){2'b10}};
    localparam logic [BW-1:0] ONES = '1;
    localparam logic [BW-1:0] ZERO = '0;

    logic                  clock = 1'b0;
    logic                  rstn, clr, inv;
    logic [1:0]            mode;
    logic [LANES*BW-1:0]   din;
    logic [LANES-1:0]      dipush;
    logic [LANES-1:0]      locked, sLocked;
    logic [LANES*ECW-1:0]  errCnt;
    logic [LANES*RCW-1:0]  recvCnt;
    logic [LANES*SECW-1:0] sErrCnt;
    logic [LANES*SRCW-1:0] sRecvCnt;
    logic                  errAny, sErrAny;

    int vectors = 0;
    int miscompares = 0;

    bit                mLocked[LANES];
    int                mGood[LANES], mBad[LANES], pW[LANES];
    longint unsigned   mErr[LANES], mRecv[LANES];
    bit                mErrAny;
    logic [BW-1:0]     mHist[LANES];
    bit                mHv[LANES], pValid[LANES];
    logic [1:0]        mPrevMode;
    bit [6:0]          gen[LANES];

    bert_check #(.BW(BW), .LANES(LANES), .ECW(ECW), .RCW(RCW), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N)) u_dut (
        .CLK(clock), .RSTX(rstn), .CLR(clr), .MODE(mode), .INV(inv), .DIN(din), .DIPUSH(dipush),
        .LOCKED(locked), .ERR_CNT(errCnt), .RECV_CNT(recvCnt), .ERR_ANY(errAny));

    bert_check #(.BW(BW), .LANES(LANES), .ECW(SECW), .RCW(SRCW), .LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N)) u_sat (
        .CLK(clock), .RSTX(rstn), .CLR(clr), .MODE(mode), .INV(inv), .DIN(din), .DIPUSH(dipush),
        .LOCKED(sLocked), .ERR_CNT(sErrCnt), .RECV_CNT(sRecvCnt), .ERR_ANY(sErrAny));

    always #5 clock = ~clock;

    function automatic longint unsigned clampTo(longint unsigned v, int w);
        longint unsigned mx;
        if (w >= 64) return v;
        mx = (64'd1 << w) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    // Bit errors of one word judged against the pattern; PRBS7 bits are predicted from the received stream.
    function automatic int wordErrors(logic [BW-1:0] d, logic [BW-1:0] prev, logic [1:0] md);
        logic [2*BW-1:0] st;
        logic [BW-1:0]   pat;
        int n;
        n = 0;
        if (md == 2'd0) begin
            st = {d, prev};
            for (int k = 0; k < BW; k++)
                if (d[k] != (st[BW+k-6] ^ st[BW+k-7])) n++;
        end else begin
            for (int k = 0; k < BW; k++) pat[k] = (md == 2'd1) ? (k % 2 == 1) : (md == 2'd3);
            n = $countones(d ^ pat);
        end
        return n;
    endfunction

    function automatic logic [BW-1:0] nextPrbs(int l);
        logic [BW-1:0] wd;
        bit b;
        for (int k = 0; k < BW; k++) begin
            b      = gen[l][1] ^ gen[l][0];
            wd[k]  = b;
            gen[l] = {b, gen[l][6:1]};
        end
        return wd;
    endfunction

    function automatic logic [BW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [BW-1:0] patternWord(int l, logic [1:0] md);
        case (md)
            2'd0:    return nextPrbs(l);
            2'd1:    return ALT;
            2'd2:    return ZERO;
            default: return ONES;
        endcase
    endfunction

    task automatic modelReset();
        for (int l = 0; l < LANES; l++) begin
            mLocked[l] = 0; mGood[l] = 0; mBad[l] = 0; pW[l] = 0;
            mErr[l] = 0; mRecv[l] = 0; mHist[l] = '0; mHv[l] = 0; pValid[l] = 0;
        end
        mErrAny   = 0;
        mPrevMode = 2'd0;
    endtask

    // Advances the model across one rising edge using the inputs currently applied.
    task automatic modelEdge();
        bit mc, hit;
        logic [BW-1:0] d;
        mc = (mode != mPrevMode);
        mPrevMode = mode;
        hit = 0;
        for (int l = 0; l < LANES; l++) begin
            if (pValid[l]) begin
                if (mLocked[l]) begin
                    if (!clr) begin
                        mRecv[l] += 1;
                        mErr[l]  += longint'(pW[l]);
                        if (pW[l] != 0) hit = 1;
                    end
                    if (pW[l] != 0) begin
                        mBad[l]++;
                        if (mBad[l] == UNLOCK_N) begin mLocked[l] = 0; mGood[l] = 0; end
                    end else mBad[l] = 0;
                end else begin
                    if (pW[l] == 0) begin
                        mGood[l]++;
                        if (mGood[l] == LOCK_N) begin mLocked[l] = 1; mBad[l] = 0; end
                    end else mGood[l] = 0;
                end
            end
            if (mc) begin mLocked[l] = 0; mGood[l] = 0; mBad[l] = 0; mHv[l] = 0; end
            if (clr) begin mErr[l] = 0; mRecv[l] = 0; end
            pValid[l] = 0;
            if (dipush[l]) begin
                d = inv ? ~din[l*BW +: BW] : din[l*BW +: BW];
                if (mode != 2'd0 || mHv[l]) begin
                    pValid[l] = 1;
                    pW[l] = wordErrors(d, mHist[l], mode);
                end
                mHist[l] = d;
                mHv[l] = 1;
            end
        end
        mErrAny = clr ? 0 : (mErrAny | hit);
    endtask

    task automatic cmp(string tag, logic [127:0] got, logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [LANES-1:0]      eL;
        logic [LANES*ECW-1:0]  eE;
        logic [LANES*RCW-1:0]  eR;
        logic [LANES*SECW-1:0] sE;
        logic [LANES*SRCW-1:0] sR;
        for (int l = 0; l < LANES; l++) begin
            eL[l]               = mLocked[l];
            eE[l*ECW +: ECW]    = ECW'(clampTo(mErr[l], ECW));
            eR[l*RCW +: RCW]    = RCW'(clampTo(mRecv[l], RCW));
            sE[l*SECW +: SECW]  = SECW'(clampTo(mErr[l], SECW));
            sR[l*SRCW +: SRCW]  = SRCW'(clampTo(mRecv[l], SRCW));
        end
        cmp("locked",      128'(locked),   128'(eL));
        cmp("err_cnt",     128'(errCnt),   128'(eE));
        cmp("recv_cnt",    128'(recvCnt),  128'(eR));
        cmp("err_any",     128'(errAny),   128'(mErrAny));
        cmp("sat_locked",  128'(sLocked),  128'(eL));
        cmp("sat_err_cnt", 128'(sErrCnt),  128'(sE));
        cmp("sat_recv",    128'(sRecvCnt), 128'(sR));
        cmp("sat_err_any", 128'(sErrAny),  128'(mErrAny));
    endtask

    task automatic applyStimulus(logic [LANES-1:0] push, logic [LANES*BW-1:0] data, logic c);
        @(negedge clock);
        dipush = push;
        din    = data;
        clr    = c;
        modelEdge();
        @(posedge clock);
        #1 checkOutput();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus('0, {rnd64(), rnd64()}, 1'b0);
    endtask

    initial begin
        logic [BW-1:0] w0, w1;
        logic [LANES*BW-1:0] data;
        logic [LANES-1:0] p;
        logic p1;
        longint unsigned recvSnap;

        rstn = 1'b0; clr = 1'b0; mode = 2'd0; inv = 1'b0; din = '0; dipush = '0;
        modelReset();
        repeat (2) @(posedge clock);
        #1 checkOutput();
        #2 rstn = 1'b1;

        // Lock and count on lane 0 with the alternating pattern; lane 1 idle.
        mode = 2'd1;
        idle(2);
        for (int i = 0; i < 20; i++) applyStimulus(2'b01, {rnd64(), ALT}, 1'b0);
        idle(2);
        cmp("p1_recv0",   128'(recvCnt[RCW-1:0]),   128'd4);
        cmp("p1_err0",    128'(errCnt[ECW-1:0]),    128'd0);
        cmp("p1_locked1", 128'(locked[1]),          128'd0);
        cmp("p1_recv1",   128'(recvCnt[RCW +: RCW]), 128'd0);

        // PRBS7 with single flipped bits at 10 and 62.
        mode = 2'd0;
        idle(2);
        gen[0] = 7'($urandom_range(1, 127));
        gen[1] = 7'($urandom_range(1, 127));
        for (int i = 1; i <= 61; i++) begin
            w0 = nextPrbs(0);
            if (i == 41) w0[10] = ~w0[10];
            if (i == 52) w0[62] = ~w0[62];
            p1 = ($urandom_range(0, 1) == 1);
            w1 = p1 ? nextPrbs(1) : rnd64();
            applyStimulus({p1, 1'b1}, {w1, w0}, 1'b0);
            if (i == 44) cmp("prbs_bit10", 128'(errCnt[ECW-1:0]), 128'd3);
        end
        idle(2);
        cmp("prbs_bit62", 128'(errCnt[ECW-1:0]), 128'd6);
        cmp("prbs_any",   128'(errAny),          128'd1);
        cmp("prbs_lock0", 128'(locked[0]),       128'd1);

        // Loss of lock in all-zeros mode, with the narrow instance saturating.
        mode = 2'd2;
        idle(2);
        for (int i = 0; i < 20; i++) applyStimulus({($urandom_range(0, 1) == 1), 1'b1}, '0, 1'b0);
        idle(2);
        recvSnap = mRecv[0];
        for (int i = 0; i < 4; i++) applyStimulus(2'b01, {ZERO, ONES}, 1'b0);
        idle(2);
        cmp("loss_err0",   128'(errCnt[ECW-1:0]),   128'd262);
        cmp("loss_recv0",  128'(recvCnt[RCW-1:0]),  128'(recvSnap + 4));
        cmp("loss_lock0",  128'(locked[0]),         128'd0);
        cmp("sat_err0",    128'(sErrCnt[SECW-1:0]), 128'd255);
        for (int i = 0; i < 2; i++) applyStimulus(2'b01, {ZERO, ONES}, 1'b0);
        idle(2);
        cmp("hold_err0",   128'(errCnt[ECW-1:0]),   128'd262);
        cmp("hold_recv0",  128'(recvCnt[RCW-1:0]),  128'(recvSnap + 4));
        cmp("hold_sat0",   128'(sErrCnt[SECW-1:0]), 128'd255);
        applyStimulus('0, '0, 1'b1);
        cmp("clr_err0",    128'(errCnt[ECW-1:0]),   128'd0);
        cmp("clr_sat0",    128'(sErrCnt[SECW-1:0]), 128'd0);

        // CLR in the same cycle a locked erroneous word reaches the counters.
        for (int i = 0; i < 16; i++) applyStimulus(2'b01, '0, 1'b0);
        applyStimulus(2'b01, {ZERO, ONES}, 1'b0);
        applyStimulus('0, '0, 1'b1);
        idle(1);
        cmp("coll_err0",  128'(errCnt[ECW-1:0]),  128'd0);
        cmp("coll_recv0", 128'(recvCnt[RCW-1:0]), 128'd0);
        cmp("coll_any",   128'(errAny),           128'd0);
        cmp("coll_lock0", 128'(locked[0]),        128'd1);

        // Randomized traffic across all modes with sparse bit errors and clears.
        for (int i = 0; i < 320; i++) begin
            if (i % 40 == 0) begin
                mode = 2'($urandom_range(0, 3));
                inv  = ($urandom_range(0, 1) == 1);
                idle(2);
            end
            for (int l = 0; l < LANES; l++) begin
                p[l] = ($urandom_range(0, 3) != 0);
                w0 = p[l] ? patternWord(l, mode) : rnd64();
                if (p[l] && $urandom_range(0, 7) == 0) w0 ^= (64'd1 << $urandom_range(0, BW - 1));
                data[l*BW +: BW] = inv ? ~w0 : w0;
            end
            applyStimulus(p, data, ($urandom_range(0, 29) == 0));
        end

        // Inverted input, then an asynchronous reset in the middle of the stream.
        applyStimulus('0, '0, 1'b1);
        mode = 2'd1;
        inv  = 1'b1;
        idle(2);
        for (int i = 0; i < 20; i++) applyStimulus(2'b01, {ZERO, ~ALT}, 1'b0);
        idle(2);
        cmp("inv_lock0", 128'(locked[0]),       128'd1);
        cmp("inv_err0",  128'(errCnt[ECW-1:0]), 128'd0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, {ZERO, ~ALT}, 1'b0);
        #1 rstn = 1'b0;
        #1;
        modelReset();
        cmp("rst_locked", 128'(locked),  128'd0);
        cmp("rst_err",    128'(errCnt),  128'd0);
        cmp("rst_recv",   128'(recvCnt), 128'd0);
        cmp("rst_any",    128'(errAny),  128'd0);
        checkOutput();
        #1 rstn = 1'b1;
        idle(1);
        for (int i = 0; i < 15; i++) applyStimulus(2'b01, {ZERO, ~ALT}, 1'b0);
        idle(2);
        cmp("relock_15", 128'(locked[0]), 128'd0);
        applyStimulus(2'b01, {ZERO, ~ALT}, 1'b0);
        idle(2);
        cmp("relock_16", 128'(locked[0]), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
